// File: rtl/usr_wide.sv
// usr_wide: parametrised universal shift register with a counted multi-step
// shift engine (GO/BUSY/DONE handshake).
// Bit 0 is the MSB (left end), bit WIDTH-1 the LSB, so Q is declared [0:WIDTH-1].
// A right shift (S0in) moves data toward higher indices; a left shift (SLin)
// moves it toward lower indices.
// Optional feature macro: USR_WIDE_ROTATE_EN adds the ROT input. With ROT=1
// the shift is a rotate and the serial inputs are ignored.
module usr_wide #(
  parameter int WIDTH = 36,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
`ifdef USR_WIDE_ROTATE_EN
  input  logic             ROT,
`endif
  input  logic [1:0]       SEL,
  input  logic [0:WIDTH-1] D,
  input  logic             S0,
  input  logic             SL,
  input  logic [CW-1:0]    CNT,
  input  logic             GO,
  output logic [0:WIDTH-1] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             SO0,
  output logic             SOL
);

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_S0IN = 2'b01;
  localparam logic [1:0] SEL_SLIN = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  logic [0:WIDTH-1] q_reg, q_next;
  logic [0:WIDTH-1] shr_vec, shl_vec;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [1:0]       mode_reg, mode_next;
  logic             rot_eff;
  logic             in_right, in_left;

`ifdef USR_WIDE_ROTATE_EN
  logic rot_reg;

  // A counted operation uses the ROT value captured with GO; idle steps use it live.
  assign rot_eff = busy_reg ? rot_reg : ROT;

  // Capture ROT whenever a GO is sampled while idle; held for the whole operation.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rot_reg <= 1'b0;
    end else if (!busy_reg && GO) begin
      rot_reg <= ROT;
    end
  end
`else
  assign rot_eff = 1'b0;
`endif

  // Bit entering at each end: the serial input, or the opposite end when rotating.
  assign in_right = rot_eff ? q_reg[WIDTH-1] : S0;
  assign in_left  = rot_eff ? q_reg[0]       : SL;

  // One-step shifted images of the register, built per bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_first
        assign shr_vec[gi] = in_right;
      end else begin : g_rest_r
        assign shr_vec[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_last
        assign shl_vec[gi] = in_left;
      end else begin : g_rest_l
        assign shl_vec[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Next-state logic: a counted shift in progress takes priority over all inputs.
  always_comb begin
    q_next     = q_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    count_next = count_reg;
    mode_next  = mode_reg;
    if (busy_reg) begin
      q_next     = (mode_reg == SEL_S0IN) ? shr_vec : shl_vec;
      count_next = count_reg - CW'(1);
      if (count_reg == CW'(1)) begin
        busy_next = 1'b0;
        done_next = 1'b1;
        mode_next = SEL_HOLD;
      end
    end else begin
      case (SEL)
        SEL_LOAD: q_next = D;
        SEL_S0IN, SEL_SLIN: begin
          if (GO) begin
            // GO edge: only arm the engine; the first step happens next edge.
            if (CNT != '0) begin
              busy_next  = 1'b1;
              count_next = CNT;
              mode_next  = SEL;
            end else begin
              done_next = 1'b1;
            end
          end else begin
            q_next = (SEL == SEL_S0IN) ? shr_vec : shl_vec;
          end
        end
        default: q_next = q_reg;
      endcase
    end
  end

  // State registers; reset takes effect immediately, even mid-shift.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= '0;
      mode_reg  <= SEL_HOLD;
    end else begin
      q_reg     <= q_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      count_reg <= count_next;
      mode_reg  <= mode_next;
    end
  end

  assign Q    = q_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign SO0  = q_reg[0];
  assign SOL  = q_reg[WIDTH-1];

endmodule

// File: tb/tb_usr_wide.sv
// tb_usr_wide: directed test of usr_wide (WIDTH=8) against a behavioural model.
// The model treats Q as an 8-bit number (bit 0 = MSB) and keeps pending
// counted steps in a queue. Define USR_WIDE_ROTATE_EN to exercise ROT.
module tb_usr_wide;
  localparam int W    = 8;
  localparam int CWB  = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic [1:0]     SEL = 2'b11;
  logic [0:W-1]   D = '0;
  logic           S0 = 1'b0;
  logic           SL = 1'b0;
  logic [CWB-1:0] CNT = '0;
  logic           GO = 1'b0;
  logic           rot = 1'b0;
  logic [0:W-1]   Q;
  logic           BUSY, DONE, SO0, SOL;

  int n_cmp = 0;
  int n_bad = 0;

  usr_wide #(.WIDTH(W), .CW(CWB)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef USR_WIDE_ROTATE_EN
    .ROT(rot),
`endif
    .SEL(SEL), .D(D), .S0(S0), .SL(SL), .CNT(CNT), .GO(GO),
    .Q(Q), .BUSY(BUSY), .DONE(DONE), .SO0(SO0), .SOL(SOL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_q = 0;
  bit m_done = 1'b0;
  int m_pend[$];   // one entry per pending step: mode*2 + rot

  function automatic int mstep(input int q, input int md, input bit r, input bit s0, input bit sl);
    int b;
    if (md == 1) begin
      b = r ? (q & 1) : int'(s0);
      return (b << (W - 1)) | (q >> 1);
    end
    b = r ? ((q >> (W - 1)) & 1) : int'(sl);
    return ((q << 1) & MASK) | b;
  endfunction

  int e_tmp;
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_q    <= 0;
      m_done <= 1'b0;
      m_pend.delete();
    end else begin
      m_done <= 1'b0;
      if (m_pend.size() > 0) begin
        e_tmp = m_pend.pop_front();
        m_q <= mstep(m_q, e_tmp >> 1, bit'(e_tmp & 1), S0, SL);
        if (m_pend.size() == 0) m_done <= 1'b1;
      end else if (GO && (SEL == 2'b01 || SEL == 2'b10)) begin
        if (CNT == 0) m_done <= 1'b1;
        else for (int k = 0; k < int'(CNT); k++) m_pend.push_back(int'(SEL) * 2 + int'(rot));
      end else if (SEL == 2'b00) begin
        m_q <= int'(D);
      end else if (SEL != 2'b11) begin
        m_q <= mstep(m_q, int'(SEL), rot, S0, SL);
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge CLK) begin
    if (RESET_N) begin
      chk("q_model",    32'(Q),    32'(m_q));
      chk("busy_model", 32'(BUSY), 32'(m_pend.size() > 0));
      chk("done_model", 32'(DONE), 32'(m_done));
      chk("so0_model",  32'(SO0),  32'((m_q >> (W - 1)) & 1));
      chk("sol_model",  32'(SOL),  32'(m_q & 1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (DONE !== 1'b1 && k < maxc) begin
      @(negedge CLK);
      k++;
    end
    chk("done_seen", 32'(DONE), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);

    // Load and hold
    SEL = 2'b00; D = 8'b10100110; step();
    chk("load", 32'(Q), 32'b10100110);
    SEL = 2'b11; repeat (3) step();
    chk("hold", 32'(Q), 32'b10100110);

    // Single steps
    SEL = 2'b01; S0 = 1'b1; step();
    chk("step_r", 32'(Q), 32'b11010011);
    chk("step_r_so0", 32'(SO0), 32'd1);
    chk("step_r_sol", 32'(SOL), 32'd1);
    SEL = 2'b10; SL = 1'b0; step();
    chk("step_l", 32'(Q), 32'b10100110);
    chk("step_l_sol", 32'(SOL), 32'd0);

    // Counted shift of 3, GO held high during BUSY with junk inputs
    SEL = 2'b00; D = 8'b11110000; step();
    GO = 1'b1; SEL = 2'b01; CNT = 3; S0 = 1'b0; step();
    chk("go_busy", 32'(BUSY), 32'd1);
    chk("go_q", 32'(Q), 32'b11110000);
    SEL = 2'b00; D = 8'h00; CNT = 7; step();
    chk("cs1", 32'(Q), 32'b01111000);
    step();
    chk("cs2_busy", 32'(BUSY), 32'd1);
    step();
    chk("cs_done", 32'(DONE), 32'd1);
    chk("cs_busy0", 32'(BUSY), 32'd0);
    chk("cs_q", 32'(Q), 32'b00011110);
    // GO in the DONE cycle is accepted
    GO = 1'b1; SEL = 2'b10; CNT = 2; SL = 1'b1; step();
    chk("b2b_busy", 32'(BUSY), 32'd1);
    chk("b2b_done0", 32'(DONE), 32'd0);
    GO = 1'b0; SEL = 2'b11; step(); step();
    chk("b2b_q", 32'(Q), 32'b01111011);
    chk("b2b_done", 32'(DONE), 32'd1);
    step();
    chk("done_clear", 32'(DONE), 32'd0);

    // Zero count, then GO with LOAD
    GO = 1'b1; SEL = 2'b10; CNT = 0; step();
    chk("zc_done", 32'(DONE), 32'd1);
    chk("zc_busy", 32'(BUSY), 32'd0);
    chk("zc_q", 32'(Q), 32'b01111011);
    SEL = 2'b00; D = 8'h5A; step();
    chk("goload_q", 32'(Q), 32'h5A);
    chk("goload_done", 32'(DONE), 32'd0);

    // Count beyond WIDTH
    S0 = 1'b1; GO = 1'b1; SEL = 2'b01; CNT = 10; step();
    GO = 1'b0; SEL = 2'b11; wait_done(20);
    chk("long_q", 32'(Q), 32'hFF);
    step();

`ifdef USR_WIDE_ROTATE_EN
    SEL = 2'b00; D = 8'b10010110; step();
    rot = 1'b1; GO = 1'b1; SEL = 2'b10; CNT = 2; step();
    GO = 1'b0; SEL = 2'b11; wait_done(10);
    chk("rot2_q", 32'(Q), 32'b01011010);
    step();
    SEL = 2'b00; D = 8'b10010110; rot = 1'b0; step();
    rot = 1'b1; GO = 1'b1; SEL = 2'b10; CNT = 8; step();
    GO = 1'b0; SEL = 2'b11; rot = 1'b0; wait_done(15);
    chk("rot8_q", 32'(Q), 32'b10010110);
    rot = 1'b1; SEL = 2'b01; step();
    chk("rot_idle", 32'(Q), 32'b01001011);
    rot = 1'b0; SEL = 2'b11; step();
`endif

    // Asynchronous reset in the middle of a counted shift
    SEL = 2'b00; D = 8'b11000000; step();
    GO = 1'b1; SEL = 2'b01; CNT = 5; S0 = 1'b0; step();
    GO = 1'b0; SEL = 2'b11; step();
    chk("mid_q", 32'(Q), 32'b01100000);
    chk("mid_busy", 32'(BUSY), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_q", 32'(Q), 32'h0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1; SEL = 2'b11; step();
    chk("post_rst_q", 32'(Q), 32'h0);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
